// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings and sequencer state type
package alu_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit ALU slice with full-adder carry
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] ALUop,
    output logic       result,
    output logic       cout
);

    always_comb begin
        result = 1'b0;
        case (ALUop)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a ^ b ^ cin;
            ALU_XOR: result = a ^ b;
            default: result = 1'b0;
        endcase
    end

    // Carry is produced for every op so the chain always reflects a+b+cin.
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial sequencer driving one alu_bit_slice, LSB first
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [1:0]         op_q;
    logic               carry;
    logic               s_res, s_cout;
    logic               accept, last;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    alu_bit_slice u_slice (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (carry),
        .ALUop  (op_q),
        .result (s_res),
        .cout   (s_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            op_q   <= ALU_AND;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                op_q   <= ALUop;
                carry  <= cin;
                cnt    <= '0;
                result <= '0;
            end else if (state == RUN) begin
                result <= {s_res, result[WIDTH-1:1]};
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                carry  <= s_cout;
                // Counter parks at WIDTH-1 on the final bit rather than wrapping.
                if (last)
                    cout <= s_cout;
                else
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
